// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: turns MEM-stage load/store requests into word-aligned
// accesses, with sub-word stores done as a read-modify-write through MERGE.
module mem_access_ctrl #(
  parameter int MEM_AW     = 23,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    IDLE,
    MERGE
  } state_t;

  state_t              state;
  logic [MEM_AW-3:0]   cap_word;
  logic [1:0]          cap_lane;
  logic [1:0]          cap_size;
  logic [15:0]         cap_data;
  logic [31:0]         old_word;

  logic [1:0]          req_lane;
  logic                req_fault;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;
  logic [31:0]         load_data;
  logic [31:0]         merged;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:MEM_AW];

  // Big-endian simply mirrors the byte lane; every selector below uses the lane.
  assign req_lane  = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];
  assign req_fault = (req_size == SZ_RSVD) || ((req_size == SZ_HALF) && req_addr[0]);
  assign req_ready = (state == IDLE);

  always_comb begin
    load_byte = 8'h00;
    case (req_lane)
      2'd0: load_byte = mem_rd[7:0];
      2'd1: load_byte = mem_rd[15:8];
      2'd2: load_byte = mem_rd[23:16];
      2'd3: load_byte = mem_rd[31:24];
      default: load_byte = 8'h00;
    endcase
  end

  assign load_half = req_lane[1] ? mem_rd[31:16] : mem_rd[15:0];

  // Word loads rotate rather than fault on misalignment (ARMv4 LDR behaviour).
  always_comb begin
    load_data = 32'h0;
    case (req_size)
      SZ_WORD: begin
        case (req_lane)
          2'd0: load_data = mem_rd;
          2'd1: load_data = {mem_rd[7:0],  mem_rd[31:8]};
          2'd2: load_data = {mem_rd[15:0], mem_rd[31:16]};
          2'd3: load_data = {mem_rd[23:0], mem_rd[31:24]};
          default: load_data = mem_rd;
        endcase
      end
      SZ_HALF: load_data = {{16{req_signed & load_half[15]}}, load_half};
      SZ_BYTE: load_data = {{24{req_signed & load_byte[7]}}, load_byte};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    merged = old_word;
    if (cap_size == SZ_BYTE) begin
      case (cap_lane)
        2'd0: merged[7:0]   = cap_data[7:0];
        2'd1: merged[15:8]  = cap_data[7:0];
        2'd2: merged[23:16] = cap_data[7:0];
        2'd3: merged[31:24] = cap_data[7:0];
        default: merged = old_word;
      endcase
    end else if (cap_lane[1]) begin
      merged[31:16] = cap_data;
    end else begin
      merged[15:0] = cap_data;
    end
  end

  always_comb begin
    mem_a = 32'h0;
    if (state == MERGE) mem_a[MEM_AW-1:2] = cap_word;
    else                mem_a[MEM_AW-1:2] = req_addr[MEM_AW-1:2];
  end

  // Reset gates the write strobe directly so an interrupted merge never lands.
  always_comb begin
    mem_we = 1'b0;
    mem_wd = req_wdata;
    if (state == MERGE) begin
      mem_we = 1'b1;
      mem_wd = merged;
    end else begin
      mem_we = req_valid & req_we & (req_size == SZ_WORD) & ~req_fault;
    end
    if (!reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 32'h0;
      cap_word   <= '0;
      cap_lane   <= 2'b00;
      cap_size   <= SZ_BYTE;
      cap_data   <= 16'h0;
      old_word   <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 32'h0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else if (!req_we) begin
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
            end else if (req_size == SZ_WORD) begin
              resp_valid <= 1'b1;
            end else begin
              state    <= MERGE;
              cap_word <= req_addr[MEM_AW-1:2];
              cap_lane <= req_lane;
              cap_size <= req_size;
              cap_data <= req_wdata[15:0];
              old_word <= mem_rd;
            end
          end
        end
        MERGE: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
